// File: rtl/ps2_pkg.sv
// ============================================================================
// ps2_pkg : shared PS/2 definitions (FSM states, status bits, frame layout)
// Revision: 1.0
// ============================================================================
`default_nettype none

package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_REQ       = 3'd2,
      ST_SEND      = 3'd3,
      ST_WAIT_ACK  = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } ps2_state_t;

   // Start, 8 data, parity, stop; the host drives everything after the start bit.
   localparam int PS2_FRAME_LEN = 11;
   localparam int PS2_TX_BITS   = PS2_FRAME_LEN - 1;

   localparam int STAT_OVR  = 12;
   localparam int STAT_TO   = 11;
   localparam int STAT_NACK = 10;
   localparam int STAT_DONE = 9;
   localparam int STAT_BUSY = 8;

   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_sync_edge.sv
// ============================================================================
// ps2_sync_edge : 2-FF synchroniser for a PS/2 pad plus registered fall pulse
// Revision: 1.0
// ============================================================================
`default_nettype none

module ps2_sync_edge
   import ps2_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic pad,
   output logic sync,
   output logic fall
);

   logic meta;

   // Idle PS/2 lines float high, so the chain resets to 1 to avoid a false fall.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b1;
         sync <= 1'b1;
         fall <= 1'b0;
      end else begin
         meta <= pad;
         sync <= meta;
         fall <= sync & ~meta;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// ============================================================================
// ps2_host_tx : PS/2 host-to-device command transmitter, Wishbone-style slave
// Optional completion interrupt enabled by defining PS2_TX_INT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 2500,
   parameter int TIMEOUT_CYCLES = 375000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        STB,
   input  logic        WE,
   input  logic [31:0] DAT_I,
   output logic [31:0] DAT_O,
   output logic        ACK,
   input  logic        PS2C_in,
   input  logic        PS2D_in,
   output logic        ps2c_drive_low,
   output logic        ps2d_drive_low,
   output logic        rx_inhibit,
   output logic        INT
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES);
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]       BIT_LAST = 4'(PS2_TX_BITS - 1);

   ps2_state_t             state;
   logic [INH_W-1:0]       inh_cnt;
   logic [WD_W-1:0]        wd_cnt;
   logic [3:0]             bit_idx;
   logic [PS2_TX_BITS-1:0] tx_frame;
   logic [7:0]             last_byte;
   logic                   stb_q;
   logic                   ovr, to, nack, done;
   logic                   frame_nack;
   logic                   c_sync, c_fall, d_sync, d_fall_unused;
   logic                   bus_rise, bus_rd, bus_wr;
   logic [31:0]            status;
   logic [23:0]            dat_hi_unused;

   assign dat_hi_unused = DAT_I[31:8];

   ps2_sync_edge u_sync_c (
      .clk  (clk),
      .rst  (rst),
      .pad  (PS2C_in),
      .sync (c_sync),
      .fall (c_fall)
   );

   ps2_sync_edge u_sync_d (
      .clk  (clk),
      .rst  (rst),
      .pad  (PS2D_in),
      .sync (d_sync),
      .fall (d_fall_unused)
   );

   assign bus_rise = STB & ~stb_q;
   assign bus_rd   = bus_rise & ~WE;
   assign bus_wr   = bus_rise & WE;

   always_comb begin
      status            = '0;
      status[7:0]       = last_byte;
      status[STAT_BUSY] = (state != ST_IDLE);
      status[STAT_DONE] = done;
      status[STAT_NACK] = nack;
      status[STAT_TO]   = to;
      status[STAT_OVR]  = ovr;
   end

   // Flag sets are written after the read-clear so a coincident set wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         inh_cnt        <= '0;
         wd_cnt         <= '0;
         bit_idx        <= '0;
         tx_frame       <= '0;
         last_byte      <= '0;
         stb_q          <= 1'b0;
         ACK            <= 1'b0;
         DAT_O          <= '0;
         ovr            <= 1'b0;
         to             <= 1'b0;
         nack           <= 1'b0;
         done           <= 1'b0;
         frame_nack     <= 1'b0;
         ps2c_drive_low <= 1'b0;
         ps2d_drive_low <= 1'b0;
         rx_inhibit     <= 1'b0;
      end else begin
         stb_q <= STB;
         ACK   <= bus_rise;
         DAT_O <= '0;
         if (bus_rd) begin
            DAT_O <= status;
            ovr   <= 1'b0;
            to    <= 1'b0;
            nack  <= 1'b0;
            done  <= 1'b0;
         end
         if (bus_wr && state != ST_IDLE)
            ovr <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (bus_wr) begin
                  tx_frame       <= {1'b1, odd_parity(DAT_I[7:0]), DAT_I[7:0]};
                  last_byte      <= DAT_I[7:0];
                  frame_nack     <= 1'b0;
                  inh_cnt        <= '0;
                  ps2c_drive_low <= 1'b1;
                  rx_inhibit     <= 1'b1;
                  state          <= ST_INHIBIT;
               end
            end
            ST_INHIBIT: begin
               inh_cnt <= inh_cnt + 1'b1;
               if (inh_cnt == INH_PRE)
                  ps2d_drive_low <= 1'b1;
               if (inh_cnt == INH_LAST) begin
                  ps2c_drive_low <= 1'b0;
                  wd_cnt         <= '0;
                  state          <= ST_REQ;
               end
            end
            ST_REQ: begin
               // The first device clock already shifts out data bit 0.
               if (c_fall) begin
                  ps2d_drive_low <= ~tx_frame[0];
                  bit_idx        <= 4'd1;
                  state          <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (c_fall) begin
                  ps2d_drive_low <= ~tx_frame[bit_idx];
                  if (bit_idx == BIT_LAST)
                     state <= ST_WAIT_ACK;
                  else
                     bit_idx <= bit_idx + 1'b1;
               end
            end
            ST_WAIT_ACK: begin
               if (c_fall) begin
                  frame_nack <= d_sync;
                  if (d_sync)
                     nack <= 1'b1;
                  state <= ST_WAIT_IDLE;
               end
            end
            ST_WAIT_IDLE: begin
               if (c_sync && d_sync) begin
                  if (!frame_nack)
                     done <= 1'b1;
                  rx_inhibit <= 1'b0;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase

         if (state == ST_REQ || state == ST_SEND || state == ST_WAIT_ACK) begin
            if (c_fall) begin
               wd_cnt <= '0;
            end else if (wd_cnt == WD_LAST) begin
               ps2c_drive_low <= 1'b0;
               ps2d_drive_low <= 1'b0;
               rx_inhibit     <= 1'b0;
               to             <= 1'b1;
               state          <= ST_IDLE;
            end else begin
               wd_cnt <= wd_cnt + 1'b1;
            end
         end
      end
   end

`ifdef PS2_TX_INT_EN
   assign INT = done | nack | to;
`else
   assign INT = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// ============================================================================
// tb_ps2_host_tx : PS/2 device model + bus scoreboard for ps2_host_tx
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ps2_host_tx;

   localparam int INH  = 50;
   localparam int TMO  = 600;
   localparam int HALF = 20;
   localparam int MODE_ACK    = 0;
   localparam int MODE_NACK   = 1;
   localparam int MODE_SILENT = 2;

   logic        clk = 1'b0;
   logic        rst, stb, we;
   logic [31:0] dat_i, dat_o;
   logic        ack, ps2c_in, ps2d_in, c_low, d_low, rx_inh, intr;
   logic        dev_c_low = 1'b0, dev_d_low = 1'b0;

   int checks = 0, errors = 0;
   int dev_mode = MODE_ACK, dev_abort_at = 0, frames_done = 0, falls = 0;
   bit dev_aborted = 1'b0;

   logic [31:0] ack_q[$];
   logic [9:0]  frame_q[$];

   bit         m_ovr, m_to, m_nack, m_done, m_busy;
   logic [7:0] m_last;

   always #5 clk = ~clk;

   assign ps2c_in = ~(c_low | dev_c_low);
   assign ps2d_in = ~(d_low | dev_d_low);

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .STB(stb), .WE(we), .DAT_I(dat_i), .DAT_O(dat_o),
      .ACK(ack), .PS2C_in(ps2c_in), .PS2D_in(ps2d_in),
      .ps2c_drive_low(c_low), .ps2d_drive_low(d_low),
      .rx_inhibit(rx_inh), .INT(intr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_status();
      return {19'b0, m_ovr, m_to, m_nack, m_done, m_busy, m_last};
   endfunction

   function automatic logic [9:0] model_frame(input logic [7:0] b);
      logic par;
      par = ($countones(b) % 2 == 0);
      return {1'b1, par, b};
   endfunction

   // Bus monitor: every ACK must match the oldest outstanding access.
   always @(negedge clk) begin
      if (ack === 1'b1) begin
         if (ack_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ack_unexpected: got ACK=1 expected no ACK");
         end else begin
            chk("dat_o", dat_o, ack_q.pop_front());
         end
      end
   end

   // PS/2 device: times the inhibit, clocks the frame, samples on rising edges.
   initial begin : device
      int cnt_c, cnt_d;
      logic [9:0] got, exp;
      bit aborted;
      forever begin
         @(negedge clk);
         if (c_low !== 1'b1) continue;
         cnt_c = 0;
         cnt_d = 0;
         while (c_low === 1'b1) begin
            cnt_c++;
            if (d_low === 1'b1) cnt_d++;
            @(negedge clk);
         end
         chk("inhibit_len", cnt_c, INH);
         chk("inhibit_dlow", cnt_d, 1);
         chk("start_bit", d_low, 1'b1);
         exp = (frame_q.size() != 0) ? frame_q.pop_front() : 10'h3ff;
         if (dev_mode == MODE_SILENT) begin
            frames_done++;
            continue;
         end
         got = '0;
         aborted = 1'b0;
         for (int n = 1; n <= 11; n++) begin
            repeat (HALF) @(negedge clk);
            if (n == 11 && dev_mode == MODE_ACK) dev_d_low = 1'b1;
            dev_c_low = 1'b1;
            falls = n;
            if (n == dev_abort_at) begin
               aborted = 1'b1;
               dev_aborted = 1'b1;
               break;
            end
            repeat (HALF) @(negedge clk);
            if (n <= 10) got[n-1] = ps2d_in;
            dev_c_low = 1'b0;
         end
         repeat (HALF) @(negedge clk);
         dev_c_low = 1'b0;
         dev_d_low = 1'b0;
         if (!aborted) begin
            chk("frame_bits", {22'b0, got}, {22'b0, exp});
            frames_done++;
         end
      end
   end

   task automatic bus_write(input logic [7:0] b);
      ack_q.push_back(32'h0);
      if (m_busy) m_ovr = 1'b1;
      else begin
         m_last = b;
         m_busy = 1'b1;
         frame_q.push_back(model_frame(b));
      end
      stb = 1'b1; we = 1'b1; dat_i = {$urandom_range(0, 255), 16'h0, b};
      @(negedge clk);
      chk("wr_ack", ack, 1'b1);
      stb = 1'b0; we = 1'b0;
      @(negedge clk);
      chk("wr_ack_1cyc", ack, 1'b0);
      @(negedge clk);
   endtask

   task automatic bus_read();
      ack_q.push_back(model_status());
      m_ovr = 0; m_to = 0; m_nack = 0; m_done = 0;
      stb = 1'b1; we = 1'b0;
      @(negedge clk);
      chk("rd_ack", ack, 1'b1);
      stb = 1'b0;
      @(negedge clk);
      chk("rd_ack_1cyc", ack, 1'b0);
      chk("dat_o_idle", dat_o, 32'h0);
      @(negedge clk);
   endtask

   task automatic wait_frame(input int target);
      int n = 0;
      while (frames_done < target && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("frame_complete", frames_done, target);
   endtask

   task automatic check_int();
`ifdef PS2_TX_INT_EN
      chk("int", intr, m_done | m_nack | m_to);
`else
      chk("int", intr, 1'b0);
`endif
   endtask

   task automatic do_frame(input logic [7:0] b);
      int target;
      target = frames_done + 1;
      falls = 0;
      bus_write(b);
      wait_frame(target);
      repeat (10) @(negedge clk);
      m_busy = 1'b0;
      if (dev_mode == MODE_ACK) m_done = 1'b1;
      else m_nack = 1'b1;
      chk("lines_released", {c_low, d_low, rx_inh}, 3'b000);
      check_int();
   endtask

   initial begin : main
      logic [7:0] b1, b2;
      int n;
      rst = 1'b1; stb = 1'b0; we = 1'b0; dat_i = '0;
      m_ovr = 0; m_to = 0; m_nack = 0; m_done = 0; m_busy = 0; m_last = '0;
      repeat (3) @(negedge clk);
      chk("rst_outputs", {ack, c_low, d_low, rx_inh, intr}, 5'b0);
      chk("rst_dat_o", dat_o, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      dev_mode = MODE_ACK;
      do_frame(8'hED);
      bus_read();
      bus_read();
      do_frame(8'h00); bus_read();
      do_frame(8'hFF); bus_read();
      do_frame(8'h01); bus_read();

      dev_mode = MODE_NACK;
      do_frame(8'($urandom));
      bus_read();

      dev_mode = MODE_SILENT;
      bus_write(8'($urandom));
      repeat (INH + TMO - 15) @(negedge clk);
      chk("to_not_early", {rx_inh, d_low}, 2'b11);
      repeat (30) @(negedge clk);
      chk("to_released", {c_low, d_low, rx_inh}, 3'b000);
      m_busy = 1'b0; m_to = 1'b1;
      check_int();
      bus_read();
      check_int();

      dev_mode = MODE_ACK;
      b1 = 8'($urandom); b2 = 8'($urandom);
      n = frames_done + 1;
      falls = 0;
      bus_write(b1);
      for (int i = 0; i < 3000 && falls < 3; i++) @(negedge clk);
      chk("ovr_reach_fall3", (falls >= 3), 1'b1);
      bus_write(b2);
      bus_read();
      wait_frame(n);
      repeat (10) @(negedge clk);
      m_busy = 1'b0; m_done = 1'b1;
      bus_read();

      dev_abort_at = 5;
      falls = 0;
      bus_write(8'($urandom));
      for (int i = 0; i < 3000 && !dev_aborted; i++) @(negedge clk);
      chk("abort_reached", dev_aborted, 1'b1);
      rst = 1'b1; stb = 1'b1; we = 1'b0;
      @(negedge clk);
      chk("mid_rst_lines", {c_low, d_low, rx_inh, ack}, 4'b0000);
      chk("mid_rst_dat_o", dat_o, 32'h0);
      rst = 1'b0; stb = 1'b0;
      m_ovr = 0; m_to = 0; m_nack = 0; m_done = 0; m_busy = 0; m_last = '0;
      dev_abort_at = 0;
      repeat (3 * HALF) @(negedge clk);
      dev_aborted = 1'b0;
      bus_read();
      do_frame(8'($urandom));
      bus_read();

      for (int i = 0; i < 10; i++) begin
         dev_mode = ($urandom_range(0, 3) == 0) ? MODE_NACK : MODE_ACK;
         do_frame(8'($urandom));
         if ($urandom_range(0, 1) == 1) bus_read();
      end
      bus_read();

      repeat (5) @(negedge clk);
      if (ack_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL ack_missing: got %0d outstanding expected 0", ack_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
